// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the two-requester block-RAM port arbiter.
// Holds the arbitration state encoding and the default RAM geometry.
package bram_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// Read-ownership tag pipe: a shift register of {valid, owner} that follows
// each accepted read through the RAM latency. Cleared synchronously on rst.
module rd_tag_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] own;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      own <= '0;
    end else begin
      vld[0] <= in_valid;
      own[0] <= in_owner;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        own[i] <= own[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_owner = own[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between two valid/ready
// requesters, with optional burst lock and per-owner read-data return.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
);

  arb_state_e state, state_nxt;
  logic       last;
  logic       acc0, acc1;
  logic       tag_in_valid;
  logic       tag_valid, tag_owner;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nxt  = state;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            req0_ready = last;
            req1_ready = !last;
          end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
          end
        end
        LOCK0:   req0_ready = req0_valid;
        LOCK1:   req1_ready = req1_valid;
        default: ;
      endcase
    end
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    unique case (state)
      IDLE: begin
        if (acc0 && req0_lock)      state_nxt = LOCK0;
        else if (acc1 && req1_lock) state_nxt = LOCK1;
      end
      LOCK0: begin
        if (acc0)                            state_nxt = req0_lock ? LOCK0 : IDLE;
        else if (!req0_valid && !req0_lock)  state_nxt = IDLE;
      end
      LOCK1: begin
        if (acc1)                            state_nxt = req1_lock ? LOCK1 : IDLE;
        else if (!req1_valid && !req1_lock)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tag_in_valid = (acc0 && !req0_we) || (acc1 && !req1_we);

  rd_tag_pipe #(
    .DEPTH(1 + RAM_LAT)
  ) u_rd_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (tag_in_valid),
    .in_owner (acc1),
    .out_valid(tag_valid),
    .out_owner(tag_owner)
  );

  // The tag exits as mem_q becomes valid; capturing here gives the
  // registered one-cycle strobe and lets the idle owner's rdata hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (acc0 || acc1) begin
        last      <= acc1;
        mem_addr  <= acc1 ? req1_addr  : req0_addr;
        mem_we    <= acc1 ? req1_we    : req0_we;
        mem_wdata <= acc1 ? req1_wdata : req0_wdata;
      end else begin
        mem_we <= 1'b0;
      end
      req0_rvalid <= tag_valid && !tag_owner;
      req1_rvalid <= tag_valid && tag_owner;
      if (tag_valid && !tag_owner) req0_rdata <= mem_q;
      if (tag_valid && tag_owner)  req1_rdata <= mem_q;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: expected read returns are queued per
// owner with their due cycle; a negedge monitor pops and compares them.
module tb_bram_port_arbiter;
  import bram_port_arbiter_pkg::*;

  localparam int unsigned ADDR_W = ADDR_W_DEF;
  localparam int unsigned DATA_W = DATA_W_DEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_we, req0_lock;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready, req0_rvalid;
  logic [DATA_W-1:0] req0_rdata;
  logic              req1_valid, req1_we, req1_lock;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready, req1_rvalid;
  logic [DATA_W-1:0] req1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q;

  logic [DATA_W-1:0] ram [1024];

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc == 0) begin
      ram[5] <= 16'hAAAA;
      ram[6] <= 16'hBBBB;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_q <= ram[mem_addr];
  end

  bram_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RAM_LAT(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_lock  (req0_lock),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req0_rvalid(req0_rvalid),
    .req0_rdata (req0_rdata),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_lock  (req1_lock),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .req1_rvalid(req1_rvalid),
    .req1_rdata (req1_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_q      (mem_q)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (req0_rvalid) begin
      if (q0.size() == 0) begin
        check("req0_rvalid_unexpected", 1, 0);
      end else begin
        e = q0.pop_front();
        check("req0_rdata", int'(req0_rdata), int'(e.data));
        check("req0_rvalid_cycle", cyc, e.due);
      end
    end
    if (req1_rvalid) begin
      if (q1.size() == 0) begin
        check("req1_rvalid_unexpected", 1, 0);
      end else begin
        e = q1.pop_front();
        check("req1_rdata", int'(req1_rdata), int'(e.data));
        check("req1_rvalid_cycle", cyc, e.due);
      end
    end
  end

  // One cycle of stimulus; ready is checked mid-cycle and accepted reads
  // queue their data due two edges after the accepting edge.
  task automatic drive(input logic v0, input logic we0, input logic lk0,
                       input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic we1, input logic lk1,
                       input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic er0, input logic er1,
                       input logic [DATA_W-1:0] x0, input logic [DATA_W-1:0] x1);
    req0_valid = v0; req0_we = we0; req0_lock = lk0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_lock = lk1; req1_addr = a1; req1_wdata = d1;
    @(negedge clk);
    check("req0_ready", int'(req0_ready), int'(er0));
    check("req1_ready", int'(req1_ready), int'(er1));
    if (er0 && v0 && !we0) q0.push_back('{data: x0, due: cyc + 3});
    if (er1 && v1 && !we1) q1.push_back('{data: x1, due: cyc + 3});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = 10'h005; req0_wdata = '0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_lock = 1'b0; req1_addr = 10'h006; req1_wdata = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_req0_ready", int'(req0_ready), 0);
      check("rst_req1_ready", int'(req1_ready), 0);
      check("rst_req0_rvalid", int'(req0_rvalid), 0);
      check("rst_req1_rvalid", int'(req1_rvalid), 0);
      check("rst_mem_we", int'(mem_we), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // Contention: tie grants alternate starting with req0.
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 10'h005, 0, 1, 0, 0, 10'h006, 0, 1, 0, 16'hAAAA, 16'hBBBB);
      drive(1, 0, 0, 10'h005, 0, 1, 0, 0, 10'h006, 0, 0, 1, 16'hAAAA, 16'hBBBB);
    end
    drive(1, 0, 0, 10'h006, 0, 0, 0, 0, 0, 0, 1, 0, 16'hBBBB, 0);

    // Lock burst by req1 while req0 waits.
    drive(1, 0, 0, 10'h005, 0, 1, 1, 1, 10'h010, 16'h1111, 0, 1, 16'hAAAA, 0);
    drive(1, 0, 0, 10'h005, 0, 1, 1, 1, 10'h011, 16'h2222, 0, 1, 16'hAAAA, 0);
    drive(1, 0, 0, 10'h005, 0, 1, 1, 0, 10'h012, 16'h3333, 0, 1, 16'hAAAA, 0);
    drive(1, 0, 0, 10'h005, 0, 0, 0, 0, 0, 0, 1, 0, 16'hAAAA, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 10'h010, 0, 0, 1, 0, 16'h1111);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 10'h011, 0, 0, 1, 0, 16'h2222);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 10'h012, 0, 0, 1, 0, 16'h3333);

    // Write then immediate read of the same address.
    drive(1, 1, 0, 10'h3FF, 16'hBEEF, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 10'h3FF, 0, 0, 1, 0, 16'hBEEF);

    // Lock abort: req1 blocked one cycle, then granted.
    drive(1, 0, 1, 10'h005, 0, 0, 0, 0, 0, 0, 1, 0, 16'hAAAA, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 10'h011, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 10'h011, 0, 0, 1, 0, 16'h2222);
    idle(4);

    // Reset with a read in flight: no rvalid may follow.
    req0_valid = 1'b1; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = 10'h005;
    @(negedge clk);
    check("midrst_req0_ready", int'(req0_ready), 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);

    // Pointer is back at its reset value: tie goes to req0 again.
    drive(1, 0, 0, 10'h006, 0, 1, 0, 0, 10'h005, 0, 1, 0, 16'hBBBB, 16'hAAAA);
    drive(1, 0, 0, 10'h006, 0, 1, 0, 0, 10'h005, 0, 0, 1, 16'hBBBB, 16'hAAAA);
    idle(4);

    check("q0_pending", q0.size(), 0);
    check("q1_pending", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
